mem_responder: RTL

Terminal responder for the `mem_intf` request/response protocol: accepts requests on `mem_in`, performs byte-masked writes and synchronous reads on an internal array of 2^ADDR_WIDTH words, and returns read responses in order on `mem_out`. It sits at the far end of a chain of `mem_stage` pipeline stages and is the memory model/BRAM endpoint for cores and caches. Full throughput of one request per cycle under no backpressure, with up to 2 outstanding responses buffered.

---
 rtl/mem_responder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Terminal request/response memory endpoint: byte-masked writes, read-before-write reads, and a 2-deep in-order response buffer.
// Define MEM_RESPONDER_WRITE_RESPONSE_EN to also return a response for write-only requests.
module mem_responder #(
    parameter int         ADDR_WIDTH = 8,
    parameter int         DATA_WIDTH = 32,
    parameter int         MASK_WIDTH = 4,
    parameter int         ID_WIDTH   = 2,
    parameter logic [0:0] CLOCK_INFO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  mem_in_valid,
    output logic                  mem_in_ready,
    input  logic                  mem_in_read_enable,
    input  logic [MASK_WIDTH-1:0] mem_in_write_enable,
    input  logic [ADDR_WIDTH-1:0] mem_in_addr,
    input  logic [DATA_WIDTH-1:0] mem_in_data,
    input  logic [ID_WIDTH-1:0]   mem_in_id,

    output logic                  mem_out_valid,
    input  logic                  mem_out_ready,
    output logic                  mem_out_read_enable,
    output logic [MASK_WIDTH-1:0] mem_out_write_enable,
    output logic [ADDR_WIDTH-1:0] mem_out_addr,
    output logic [DATA_WIDTH-1:0] mem_out_data,
    output logic [ID_WIDTH-1:0]   mem_out_id,

    output logic [1:0]            outstanding
);
    localparam int LANE  = DATA_WIDTH / MASK_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    if ($bits(CLOCK_INFO) == 0 || (DATA_WIDTH % MASK_WIDTH) != 0) begin : g_bad_width
        $error("mem_responder: DATA_WIDTH must be a multiple of MASK_WIDTH");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [1:0]            count;
    logic                  wr_ptr;
    logic                  rd_ptr;

    logic                  resp_re_d;
    logic [MASK_WIDTH-1:0] resp_we_d;
    logic [DATA_WIDTH-1:0] resp_data_d;

    logic                  buf_re   [2];
    logic [MASK_WIDTH-1:0] buf_we   [2];
    logic [ADDR_WIDTH-1:0] buf_addr [2];
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [ID_WIDTH-1:0]   buf_id   [2];

    assign mem_out_valid = !rst && (count != 2'd0);
    assign pop           = mem_out_valid && mem_out_ready;
    assign mem_in_ready  = !rst && ((count < 2'd2) || pop);
    assign accept        = mem_in_valid && mem_in_ready;
    assign outstanding   = count;

`ifdef MEM_RESPONDER_WRITE_RESPONSE_EN
    assign push = accept && (mem_in_read_enable || (|mem_in_write_enable));
`else
    assign push = accept && mem_in_read_enable;
`endif

    // Response payload is taken from the array before this cycle's write lands (read-before-write).
    always_comb begin
        resp_re_d   = mem_in_read_enable;
        resp_we_d   = '0;
        resp_data_d = mem[mem_in_addr];
        if (!mem_in_read_enable) begin
            resp_we_d   = mem_in_write_enable;
            resp_data_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < MASK_WIDTH; i++) begin
                if (mem_in_write_enable[i]) begin
                    mem[mem_in_addr][i*LANE +: LANE] <= mem_in_data[i*LANE +: LANE];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_re[wr_ptr]   <= resp_re_d;
            buf_we[wr_ptr]   <= resp_we_d;
            buf_addr[wr_ptr] <= mem_in_addr;
            buf_data[wr_ptr] <= resp_data_d;
            buf_id[wr_ptr]   <= mem_in_id;
        end
    end

    // A push and pop in the same cycle leave the count unchanged, which is what lets a full buffer keep streaming.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign mem_out_read_enable  = buf_re[rd_ptr];
    assign mem_out_write_enable = buf_we[rd_ptr];
    assign mem_out_addr         = buf_addr[rd_ptr];
    assign mem_out_data         = buf_data[rd_ptr];
    assign mem_out_id           = buf_id[rd_ptr];

endmodule
